// File: rtl/systolic_feeder_if.sv
// Upstream valid/ready stream into the systolic feeder: one A column and one B row per beat.
interface systolic_feeder_if #(
  parameter int unsigned DW   = 8,
  parameter int unsigned SIZE = 4
);
  logic                 s_valid;
  logic                 s_ready;
  logic [SIZE*DW-1:0]   s_a_col;
  logic [SIZE*DW-1:0]   s_b_row;

  modport master (
    output s_valid,
    output s_a_col,
    output s_b_row,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_a_col,
    input  s_b_row,
    output s_ready
  );
endinterface

// File: rtl/systolic_feeder.sv
// Buffers a SIZE x SIZE A/B job, replays it onto the array edges with diagonal skew,
// then drains accumulated C rows out of the array bottom.
module systolic_feeder #(
  parameter int unsigned DW   = 8,
  parameter int unsigned SIZE = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  systolic_feeder_if.slave          s_if,
  output logic [SIZE*DW-1:0]        a_edge_o,
  output logic [SIZE*DW-1:0]        b_edge_o,
  output logic                      output_sign_o,
  output logic                      drain_valid_o,
  output logic [$clog2(SIZE)-1:0]   drain_row_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int unsigned BeatW = $clog2(SIZE + 1);
  localparam int unsigned StepW = $clog2(3 * SIZE);
  localparam int unsigned RowW  = $clog2(SIZE);
  localparam int unsigned VecW  = SIZE * DW;

  localparam logic [BeatW-1:0] BeatLast  = BeatW'(SIZE - 1);
  localparam logic [StepW-1:0] FeedLast  = StepW'(3 * SIZE - 3);
  localparam logic [StepW-1:0] DrainLast = StepW'(SIZE - 1);

  typedef enum logic [1:0] {StLoad, StFeed, StDrain} state_e;

  state_e           state_q, state_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic [StepW-1:0] step_q, step_d;
  logic             accept;

  logic [VecW-1:0]  a_buf_q [SIZE];
  logic [VecW-1:0]  b_buf_q [SIZE];

  logic             s_ready_q, s_ready_d;
  logic [VecW-1:0]  a_edge_q, a_edge_d;
  logic [VecW-1:0]  b_edge_q, b_edge_d;
  logic             output_sign_q, output_sign_d;
  logic             drain_valid_q, drain_valid_d;
  logic [RowW-1:0]  drain_row_q, drain_row_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // s_ready_q is high exactly while state_q is StLoad.
  assign accept = s_if.s_valid && s_ready_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StLoad;
      beat_q  <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:  if (accept && (beat_q == BeatLast)) state_d = StFeed;
      StFeed:  if (step_q == FeedLast)             state_d = StDrain;
      StDrain: if (step_q == DrainLast)            state_d = StLoad;
      default:                                     state_d = StLoad;
    endcase

    beat_d = beat_q;
    step_d = step_q;
    if (state_d != state_q) begin
      beat_d = '0;
      step_d = '0;
    end else if (state_q == StLoad) begin
      if (accept) beat_d = beat_q + 1'b1;
    end else begin
      step_d = step_q + 1'b1;
    end
  end

  // Outputs are precomputed from the next state/step so the registered edges show step t
  // during FEED cycle t.
  always_comb begin
    s_ready_d     = (state_d == StLoad);
    busy_d        = (state_d != StLoad);
    output_sign_d = (state_d == StDrain);
    drain_valid_d = (state_d == StDrain);
    drain_row_d   = '0;
    done_d        = (state_q == StDrain) && (state_d == StLoad);
    a_edge_d      = '0;
    b_edge_d      = '0;

    if (state_d == StDrain) begin
      drain_row_d = RowW'(SIZE - 1) - step_d[RowW-1:0];
    end

    if (state_d == StFeed) begin
      for (int i = 0; i < int'(SIZE); i++) begin
        if ((int'(step_d) >= i) && (int'(step_d) < i + int'(SIZE))) begin
          a_edge_d[i*DW +: DW] = a_buf_q[RowW'(int'(step_d) - i)][i*DW +: DW];
          b_edge_d[i*DW +: DW] = b_buf_q[RowW'(int'(step_d) - i)][i*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s_ready_q     <= 1'b1;
      a_edge_q      <= '0;
      b_edge_q      <= '0;
      output_sign_q <= 1'b0;
      drain_valid_q <= 1'b0;
      drain_row_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      s_ready_q     <= s_ready_d;
      a_edge_q      <= a_edge_d;
      b_edge_q      <= b_edge_d;
      output_sign_q <= output_sign_d;
      drain_valid_q <= drain_valid_d;
      drain_row_q   <= drain_row_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // Buffer contents are don't-care after reset; the beat counter alone tracks validity.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_buf_q[beat_q[RowW-1:0]] <= s_if.s_a_col;
      b_buf_q[beat_q[RowW-1:0]] <= s_if.s_b_row;
    end
  end

  assign s_if.s_ready  = s_ready_q;
  assign a_edge_o      = a_edge_q;
  assign b_edge_o      = b_edge_q;
  assign output_sign_o = output_sign_q;
  assign drain_valid_o = drain_valid_q;
  assign drain_row_o   = drain_row_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Upstream stage of the systolic matrix-multiply array; drives the array's left (A) and top (B) edges and the array-wide output_sign.
- Accepts a SIZE x SIZE A matrix (column per beat) and B matrix (row per beat) over a valid/ready stream, then replays them with diagonal skew.
- Then runs a drain phase that shifts accumulated C results down to the bottom row and clears the array for the next job.

Parameters:
- DW, 8, element width in bits; matches the PE datapath width.
- SIZE, 4, array dimension and inner dimension K; legal range 2..16.

Ports:
- clk  input  1  clock
- rstn  input  1  reset, synchronous, active-low
- s_valid  input  1  upstream beat valid
- s_ready  output  1  feeder can accept a beat
- s_a_col  input  SIZE*DW  beat k: A[i][k] at bits [i*DW +: DW]
- s_b_row  input  SIZE*DW  beat k: B[k][j] at bits [j*DW +: DW]
- a_edge  output  SIZE*DW  to array row i left input, bits [i*DW +: DW]
- b_edge  output  SIZE*DW  to array column j top input, bits [j*DW +: DW]
- output_sign  output  1  to every PE; 1 = shift C down, 0 = accumulate
- drain_valid  output  1  array bottom row holds a finished C row this cycle
- drain_row  output  clog2(SIZE)  index of the C row at the bottom row while drain_valid=1
- busy  output  1  state is FEED or DRAIN
- done  output  1  one-cycle pulse when a job completes

Behaviour:
- All outputs registered. Reset values: s_ready=1, a_edge=0, b_edge=0, output_sign=0, drain_valid=0, drain_row=0, busy=0, done=0. State=LOAD, all counters 0, buffer contents don't-care.
- Reset is honoured in any state, including mid-FEED or mid-DRAIN. The next cycle is a clean LOAD with no stale beats counted. The PEs share rstn and clear with it.
- States: LOAD -> FEED -> DRAIN -> LOAD.
- LOAD:
  - s_ready=1. A beat is accepted when s_valid && s_ready; it is stored in buffer slot k = beat counter, and the counter increments.
  - Gaps in s_valid are allowed; the counter holds during gaps.
  - On acceptance of beat SIZE-1, go to FEED and drop s_ready to 0 in the next cycle.
- FEED: runs 3*SIZE-2 cycles, with t = 0..3*SIZE-3 and the edges showing step t in FEED cycle t.
  - The first FEED cycle is the cycle after the final handshake.
  - a_edge row i = A[i][t-i] when 0 <= t-i < SIZE, else 0.
  - b_edge column j = B[t-j][j] when 0 <= t-j < SIZE, else 0.
  - output_sign=0; busy=1.
  - With one-cycle PE registers this aligns A[i][k] and B[k][j] at PE(i,j) at step k+i+j. The last product, at PE(SIZE-1,SIZE-1), is captured at the end of t=3*SIZE-3.
- DRAIN: SIZE cycles, d = 0..SIZE-1.
  - output_sign=1, a_edge=b_edge=0, busy=1. The array's top C edge is tied 0 externally.
  - drain_valid=1 and drain_row=SIZE-1-d during drain cycle d; the bottom row shows C row SIZE-1-d.
  - After SIZE shifts the array holds all zeros, so no separate clear is needed.
- Completion: in the cycle after the last DRAIN cycle, done=1 for one cycle, state=LOAD, s_ready=1, busy=0, drain_valid=0.
  - A beat may be accepted in that same cycle.
- Timing for SIZE=4, last handshake at cycle L: FEED L+1..L+10, DRAIN L+11..L+14, done and s_ready at L+15.
- s_valid while s_ready=0 is ignored. Upstream must hold data stable until the handshake.
- Arithmetic: the feeder passes elements unmodified, with no width change. Products and accumulations wrap modulo 2^DW inside the PEs.
- Counters: beat counter clog2(SIZE+1) bits; step counter clog2(3*SIZE) bits. Both reset to 0 on every state entry.

Test Plan:
- SIZE=4, A=identity, B[k][j]=4k+j+1, back-to-back beats:
  - FEED edges match the skew formula cycle by cycle; a_edge row 3 is nonzero only at t=6.
  - drain_row 3,2,1,0 shows bottom rows [13..16],[9..12],[5..8],[1..4]; done at L+15.
- Backpressure: s_valid low for 3 cycles between beats 1 and 2 -> s_ready stays 1, the counter holds, and FEED starts exactly 1 cycle after the 4th handshake.
- Wrap: A and B all 16 -> each C element = 4*256 mod 256 = 0. With all elements 3 -> C=36 everywhere.
- s_valid held high through FEED/DRAIN with changing data -> no beats accepted. Results equal the loaded job. The next job starts at the done cycle.
- rstn low for 1 cycle at FEED t=5 -> all outputs at reset values next cycle. A fresh 4-beat job then gives correct C with no residue from the aborted job.
- Two consecutive jobs (identity x B, then B x identity) -> the second result is uncontaminated, proving drain clears the accumulators.
